// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Word-organised data memory for the MIPS datapath with a
//             programmable wait-state delay, a one-cycle ready/err response
//             strobe and saturating read/write access counters.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH       = 256,  // 32-bit words, power of two
  parameter int WAIT_CYCLES = 2     // wait states between accept and response
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int         c_aw        = $clog2(DEPTH);
  localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  // Storage is deliberately left out of reset so contents survive rst.
  logic [31:0]     mem_q [DEPTH];
  logic [c_aw-1:0] word_idx;
  logic            req_ok;
  logic            mem_we;

  // Request legality is judged on the latched request, never on live inputs.
  always_comb begin
    word_idx = adr_q[c_aw+1:2];
    req_ok   = (adr_q[1:0] == 2'b00)
            && ((adr_q >> (c_aw + 2)) == 32'd0)
            && !(rd_q && wr_q);
    mem_we   = (state_q == S_RESP) && wr_q && req_ok;
  end

  // Next-state, request capture and counter update.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          adr_d   = adr;
          wdata_d = write_data;
          rd_d    = mem_read;
          wr_d    = mem_write;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            wait_cnt_d = c_wait_load;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The counter holds the remaining extra wait cycles; zero means this
        // is the last wait cycle.
        if (wait_cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (req_ok) begin
          if (rd_q && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
          if (wr_q && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      adr_q      <= 32'd0;
      wdata_q    <= 32'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Store commits at the end of the response cycle; reset suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[word_idx] <= wdata_q;
    end
  end

  // Response outputs are derived from registered state only.
  always_comb begin
    ready     = (state_q == S_RESP);
    err       = ready && !req_ok;
    read_data = (ready && req_ok && rd_q) ? mem_q[word_idx] : 32'd0;
    rd_count  = rd_count_q;
    wr_count  = wr_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder. Two instances
//             (WAIT_CYCLES 2 and 0) are compared every cycle against a
//             timestamp-based transaction model; directed cases pin the
//             model with literal expectations, then random traffic runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam int          NW    = 2;
  localparam int unsigned BYTES = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [NW];
  logic        rd_i    [NW];
  logic        wr_i    [NW];
  logic [31:0] adr_i   [NW];
  logic [31:0] wd_i    [NW];
  logic [31:0] rdata_o [NW];
  logic        ready_o [NW];
  logic        err_o   [NW];
  logic [15:0] rdc_o   [NW];
  logic [15:0] wrc_o   [NW];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst[0]), .mem_read(rd_i[0]), .mem_write(wr_i[0]),
    .adr(adr_i[0]), .write_data(wd_i[0]), .read_data(rdata_o[0]),
    .ready(ready_o[0]), .err(err_o[0]), .rd_count(rdc_o[0]), .wr_count(wrc_o[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst[1]), .mem_read(rd_i[1]), .mem_write(wr_i[1]),
    .adr(adr_i[1]), .write_data(wd_i[1]), .read_data(rdata_o[1]),
    .ready(ready_o[1]), .err(err_o[1]), .rd_count(rdc_o[1]), .wr_count(wrc_o[1])
  );

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %h expected %h (t=%0t)", i, nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // A request accepted at edge n is answered in the cycle after edge n+W,
  // retires (commit + count) at edge n+W+1, and the next request can be
  // accepted no earlier than edge n+W+2.
  int unsigned edge_n = 0;
  bit          m_busy [NW];
  int unsigned m_resp [NW];
  int unsigned m_next [NW];
  logic        m_rd   [NW];
  logic        m_wr   [NW];
  logic [31:0] m_adr  [NW];
  logic [31:0] m_wd   [NW];
  logic [15:0] m_rdc  [NW];
  logic [15:0] m_wrc  [NW];
  logic [31:0] m_mem  [NW][DEPTH];
  bit          check_en = 1'b0;

  function automatic bit m_ok(input int i);
    return (m_adr[i] % 4 == 0) && (m_adr[i] < BYTES) && !(m_rd[i] && m_wr[i]);
  endfunction

  function automatic int m_word(input int i);
    return int'((m_adr[i] / 4) % DEPTH);
  endfunction

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < NW; i++) begin
      if (rst[i]) begin
        m_busy[i] = 1'b0;
        m_rdc[i]  = 16'd0;
        m_wrc[i]  = 16'd0;
        m_next[i] = edge_n + 1;
      end else begin
        if (m_busy[i] && edge_n == m_resp[i] + 1) begin
          if (m_ok(i)) begin
            if (m_wr[i]) begin
              m_mem[i][m_word(i)] = m_wd[i];
              if (m_wrc[i] != 16'hFFFF) m_wrc[i] = m_wrc[i] + 16'd1;
            end
            if (m_rd[i] && m_rdc[i] != 16'hFFFF) m_rdc[i] = m_rdc[i] + 16'd1;
          end
          m_busy[i] = 1'b0;
        end
        if (!m_busy[i] && edge_n >= m_next[i] && (rd_i[i] || wr_i[i])) begin
          m_busy[i] = 1'b1;
          m_rd[i]   = rd_i[i];
          m_wr[i]   = wr_i[i];
          m_adr[i]  = adr_i[i];
          m_wd[i]   = wd_i[i];
          m_resp[i] = edge_n + wc(i);
          m_next[i] = edge_n + wc(i) + 2;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NW; i++) begin
        bit          rexp;
        logic [31:0] dexp;
        rexp = m_busy[i] && (edge_n == m_resp[i]);
        dexp = (rexp && m_ok(i) && m_rd[i]) ? m_mem[i][m_word(i)] : 32'd0;
        chk(i, "ready", 32'(ready_o[i]), 32'(rexp));
        chk(i, "err", 32'(err_o[i]), 32'(rexp && !m_ok(i)));
        chk(i, "read_data", rdata_o[i], dexp);
        chk(i, "rd_count", 32'(rdc_o[i]), 32'(m_rdc[i]));
        chk(i, "wr_count", 32'(wrc_o[i]), 32'(m_wrc[i]));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Issue one request, wait (bounded) for ready, check latency, and drop the
  // request in the ready cycle. With hold set the request is kept through
  // the following IDLE cycle and must be answered a second time.
  task automatic do_req(input int i, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input bit hold,
                        output logic [31:0] rdat, output logic e, output int nrdy);
    int  lat;
    bit  got;
    bit  dead;
    @(negedge clk);
    rd_i[i] = r; wr_i[i] = w; adr_i[i] = a; wd_i[i] = d;
    rdat = 32'd0; e = 1'b0; nrdy = 0; dead = 1'b0;
    for (int k = 0; k < (hold ? 2 : 1); k++) begin
      if (!dead) begin
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
          @(negedge clk);
          if (ready_o[i]) begin got = 1'b1; lat = c; end
        end
        if (!got) begin
          chk(i, "ready timeout", 32'd0, 32'd1);
          dead = 1'b1;
        end else begin
          nrdy++;
          rdat = rdata_o[i];
          e    = err_o[i];
          chk(i, "latency", 32'(lat), 32'(wc(i) + 1 + k));
        end
      end
    end
    rd_i[i] = 1'b0; wr_i[i] = 1'b0;
  endtask

  logic [31:0] rv;
  logic        ev;
  int          nv;

  initial begin
    for (int i = 0; i < NW; i++) begin
      rst[i] = 1'b1; rd_i[i] = 1'b0; wr_i[i] = 1'b0; adr_i[i] = 32'd0; wd_i[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NW; i++) rst[i] = 1'b0;
    check_en = 1'b1;
    for (int i = 0; i < NW; i++) begin
      chk(i, "reset ready", 32'(ready_o[i]), 32'd0);
      chk(i, "reset err", 32'(err_o[i]), 32'd0);
      chk(i, "reset read_data", rdata_o[i], 32'd0);
      chk(i, "reset rd_count", 32'(rdc_o[i]), 32'd0);
      chk(i, "reset wr_count", 32'(wrc_o[i]), 32'd0);
    end

    // --- WAIT_CYCLES = 2 directed cases
    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rv, ev, nv);
    chk(0, "wr10 err", 32'(ev), 32'd0);
    @(negedge clk);
    chk(0, "wr10 wr_count", 32'(wrc_o[0]), 32'd1);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rv, ev, nv);
    chk(0, "rd10 data", rv, 32'hDEADBEEF);
    @(negedge clk);
    chk(0, "rd10 rd_count", 32'(rdc_o[0]), 32'd1);
    do_req(0, 1'b1, 1'b0, 32'h6, 32'h0, 1'b0, rv, ev, nv);
    chk(0, "misaligned err", 32'(ev), 32'd1);
    chk(0, "misaligned data", rv, 32'd0);
    do_req(0, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, rv, ev, nv);
    do_req(0, 1'b0, 1'b1, 32'h400, 32'h00000BAD, 1'b0, rv, ev, nv);
    chk(0, "oor err", 32'(ev), 32'd1);
    do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rv, ev, nv);
    chk(0, "after oor data", rv, 32'h12345678);
    do_req(0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, rv, ev, nv);
    chk(0, "both err", 32'(ev), 32'd1);
    @(negedge clk);
    chk(0, "both wr_count", 32'(wrc_o[0]), 32'd2);
    chk(0, "both rd_count", 32'(rdc_o[0]), 32'd2);
    do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rv, ev, nv);
    chk(0, "after both data", rv, 32'h12345678);

    // Reset during WAIT discards an in-flight write.
    do_req(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, rv, ev, nv);
    @(negedge clk);
    rd_i[0] = 1'b0; wr_i[0] = 1'b1; adr_i[0] = 32'h20; wd_i[0] = 32'h55;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0; wr_i[0] = 1'b0;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready_o[0]) nv++;
    end
    chk(0, "rst no ready", 32'(nv), 32'd0);
    chk(0, "rst rd_count", 32'(rdc_o[0]), 32'd0);
    chk(0, "rst wr_count", 32'(wrc_o[0]), 32'd0);
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rv, ev, nv);
    chk(0, "rst prior data", rv, 32'hA5A5A5A5);

    // --- WAIT_CYCLES = 0 directed cases
    do_req(1, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0, rv, ev, nv);
    do_req(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rv, ev, nv);
    chk(1, "w0 read", rv, 32'h1);
    do_req(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, rv, ev, nv);
    chk(1, "held readies", 32'(nv), 32'd2);
    chk(1, "held data", rv, 32'h1);

    // --- random traffic over a fully initialised 16-word window
    for (int i = 0; i < NW; i++)
      for (int k = 0; k < 16; k++)
        do_req(i, 1'b0, 1'b1, 32'(k * 4), $urandom, 1'b0, rv, ev, nv);
    for (int i = 0; i < NW; i++) begin
      for (int k = 0; k < 80; k++) begin
        int          sel;
        logic        r, w;
        logic [31:0] a;
        sel = int'($urandom_range(0, 9));
        a   = 32'($urandom_range(0, 15)) * 32'd4;
        r   = (sel < 4);
        w   = (sel >= 4 && sel < 8);
        if (sel == 8) begin r = 1'b1; w = 1'b1; end
        if (sel == 9) begin
          r = 1'($urandom_range(0, 1));
          w = !r;
          a = a | 32'($urandom_range(1, 3));
        end
        if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(10, 31));
        do_req(i, r, w, a, $urandom, 1'b0, rv, ev, nv);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    // --- write counter saturation
    @(posedge clk);
    #2;
    force dut0.wr_count_q = 16'hFFFE;
    m_wrc[0] = 16'hFFFE;
    @(posedge clk);
    #2;
    release dut0.wr_count_q;
    for (int k = 0; k < 3; k++)
      do_req(0, 1'b0, 1'b1, 32'hC, 32'(k), 1'b0, rv, ev, nv);
    @(negedge clk);
    chk(0, "saturated wr_count", 32'(wrc_o[0]), 32'h0000FFFF);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS processor. It services the processor's data-memory requests (mem_read / mem_write, byte address, write data) from a word-organised storage array. A programmable wait-state counter and a one-cycle ready handshake let the datapath be exercised against a non-zero-latency memory. The block also reports misaligned, out-of-range and conflicting requests, and keeps saturating access counters for bench visibility.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, 4..65536.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and response; 0..15.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  read request; held by the processor until ready.
- mem_write  input  1  write request; held by the processor until ready.
- adr  input  32  byte address; held stable with the request.
- write_data  input  32  store data; held stable with the request.
- read_data  output  32  load data; valid only in the ready cycle, 0 otherwise.
- ready  output  1  one-cycle response strobe.
- err  output  1  one-cycle strobe, coincident with ready, when the request was rejected.
- rd_count  output  16  accepted successful reads; saturates at 16'hFFFF.
- wr_count  output  16  accepted successful writes; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read or mem_write is high, latch adr, write_data and the request type.
  - If WAIT_CYCLES = 0, go to RESP; otherwise load the wait counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter; go to RESP when it is 0. Inputs are not re-sampled here, so changes during WAIT are ignored.
- RESP:
  - Assert ready for exactly one cycle, then return to IDLE.
  - A successful write commits mem[word] <= latched write_data at the end of RESP.
  - A successful read drives read_data = mem[word] during RESP.
- Word index = adr[log2(DEPTH)+1 : 2].
- Error conditions, evaluated on the latched request:
  - adr[1:0] != 0 (misaligned);
  - any adr bit above log2(DEPTH)+1 set (out of range);
  - mem_read and mem_write both high.
- On error:
  - ready and err are both asserted.
  - read_data = 0.
  - No memory write occurs.
  - Neither counter increments.
- rd_count / wr_count increment by 1 in the RESP cycle of a successful read or write and hold at 16'hFFFF.
- Memory contents are not cleared by rst.

## Timing
- Reset values: read_data = 0, ready = 0, err = 0, rd_count = 0, wr_count = 0, state = IDLE, wait counter = 0.
- Latency: ready asserts exactly WAIT_CYCLES+1 cycles after the rising edge that sampled the request in IDLE. With WAIT_CYCLES = 0, ready is high in the cycle after acceptance.
- Throughput: at most one request per WAIT_CYCLES+2 cycles. After RESP the FSM spends one cycle in IDLE.
- Request still high in the IDLE cycle after ready: treated as a new request. The processor must drop the request the cycle after ready unless it intends to re-issue it.
- Read-after-write to the same word: the later read returns the newly written data.
- rst asserted in any state:
  - The next edge forces IDLE and clears the outputs and counters.
  - An in-flight write in WAIT is discarded (not committed).
  - A write in RESP with rst high is not committed.

## Test plan
- Write then read, WAIT_CYCLES = 2:
  - Write adr 32'h10, data 32'hDEADBEEF. ready rises 3 cycles after acceptance, err = 0, wr_count = 1.
  - Read adr 32'h10. read_data = 32'hDEADBEEF in the ready cycle, rd_count = 1.
- WAIT_CYCLES = 0 back-to-back:
  - Write adr 0 = 32'h1, then read adr 0. Each ready follows acceptance by 1 cycle; read returns 32'h1.
  - Request held high across the IDLE cycle after ready is re-accepted.
- Errors:
  - Read adr 32'h6 (misaligned) gives ready = err = 1 and read_data = 0.
  - Write adr 32'h400 with DEPTH = 256 (out of range) gives err = 1; a subsequent read of adr 0 is unchanged.
  - mem_read and mem_write both high gives err = 1, no write, and counters unchanged.
- Reset mid-operation:
  - Write adr 32'h20 = 32'h55, with rst pulsed during WAIT. ready never asserts, outputs return to 0, and a later read of 32'h20 returns its prior value.
- Counter saturation: preload or force wr_count = 16'hFFFE, then perform 3 successful writes. wr_count ends at 16'hFFFF.
- Processor integration: run the processor with this block as data memory on a load/store program (sw then lw, same address). The loaded register equals the stored value; the bench checks ready latency on every access.
